// File: rtl/rename_table.sv
// Register rename stage: speculative and retirement architectural-to-physical maps,
// a one-entry registered output slot, free-list handshake, commit and flush recovery.
module rename_table #(
    parameter int unsigned ARCH_REGS = 16,
    parameter int unsigned PHYS_REGS = 32,
    localparam int unsigned AW = $clog2(ARCH_REGS),
    localparam int unsigned PW = $clog2(PHYS_REGS)
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_src1,
    input  logic [AW-1:0] in_src2,
    input  logic [AW-1:0] in_dst,
    input  logic          in_dst_en,
    input  logic          fl_avail,
    input  logic [PW-1:0] fl_tag,
    output logic          fl_checkout,
    output logic          fl_checkin,
    output logic [PW-1:0] fl_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_psrc1,
    output logic [PW-1:0] out_psrc2,
    output logic [PW-1:0] out_pdst,
    output logic [PW-1:0] out_pold,
    output logic          out_dst_en,
    input  logic          commit_valid,
    input  logic          commit_dst_en,
    input  logic [AW-1:0] commit_arch,
    input  logic [PW-1:0] commit_pdst,
    input  logic [PW-1:0] commit_pold,
    input  logic          flush
);

    logic [PW-1:0] spec_map_q [ARCH_REGS];
    logic [PW-1:0] spec_map_d [ARCH_REGS];
    logic [PW-1:0] ret_map_q  [ARCH_REGS];
    logic [PW-1:0] ret_map_d  [ARCH_REGS];

    logic          out_valid_q, out_valid_d;
    logic [PW-1:0] out_psrc1_q, out_psrc1_d;
    logic [PW-1:0] out_psrc2_q, out_psrc2_d;
    logic [PW-1:0] out_pdst_q,  out_pdst_d;
    logic [PW-1:0] out_pold_q,  out_pold_d;
    logic          out_dst_en_q, out_dst_en_d;

    logic xfer;
    logic commit_fire;

    // Handshake: held output must drain, a destination needs a free tag, flush blocks rename
    assign in_ready    = n_rst && (!out_valid_q || out_ready) && (!in_dst_en || fl_avail) && !flush;
    assign xfer        = in_valid && in_ready;
    assign fl_checkout = xfer && in_dst_en;
    assign commit_fire = n_rst && commit_valid && commit_dst_en;
    assign fl_checkin  = commit_fire;
    assign fl_in       = commit_pold;

    assign out_valid   = out_valid_q;
    assign out_psrc1   = out_psrc1_q;
    assign out_psrc2   = out_psrc2_q;
    assign out_pdst    = out_pdst_q;
    assign out_pold    = out_pold_q;
    assign out_dst_en  = out_dst_en_q;

    // Next-state: commit updates ret_map first so a same-cycle flush restores it
    always_comb begin
        spec_map_d   = spec_map_q;
        ret_map_d    = ret_map_q;
        out_valid_d  = out_valid_q;
        out_psrc1_d  = out_psrc1_q;
        out_psrc2_d  = out_psrc2_q;
        out_pdst_d   = out_pdst_q;
        out_pold_d   = out_pold_q;
        out_dst_en_d = out_dst_en_q;

        if (commit_fire) begin
            ret_map_d[commit_arch] = commit_pdst;
        end

        if (flush) begin
            spec_map_d  = ret_map_d;
            out_valid_d = 1'b0;
        end else if (xfer) begin
            // Sources and old mapping read before this instruction's own update
            out_valid_d  = 1'b1;
            out_psrc1_d  = spec_map_q[in_src1];
            out_psrc2_d  = spec_map_q[in_src2];
            out_pold_d   = spec_map_q[in_dst];
            out_pdst_d   = in_dst_en ? fl_tag : '0;
            out_dst_en_d = in_dst_en;
            if (in_dst_en) begin
                spec_map_d[in_dst] = fl_tag;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            for (int i = 0; i < int'(ARCH_REGS); i++) begin
                spec_map_q[i] <= PW'(i);
                ret_map_q[i]  <= PW'(i);
            end
            out_valid_q  <= 1'b0;
            out_psrc1_q  <= '0;
            out_psrc2_q  <= '0;
            out_pdst_q   <= '0;
            out_pold_q   <= '0;
            out_dst_en_q <= 1'b0;
        end else begin
            spec_map_q   <= spec_map_d;
            ret_map_q    <= ret_map_d;
            out_valid_q  <= out_valid_d;
            out_psrc1_q  <= out_psrc1_d;
            out_psrc2_q  <= out_psrc2_d;
            out_pdst_q   <= out_pdst_d;
            out_pold_q   <= out_pold_d;
            out_dst_en_q <= out_dst_en_d;
        end
    end

endmodule
